vector_capture: RTL and testbench
=================================

VECTOR_CAPTURE -- requirements
Module: vector_capture

Interface
REQ-001 Parameter DEPTH, default 16, number of 96-bit records held (power of two, >=2).
REQ-002 Parameter DATA_WIDTH, default 32, width of each captured operand/result field.
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port arm  input  1  one-cycle pulse; starts a capture session.
REQ-006 Port stop  input  1  one-cycle pulse; ends the session.
REQ-007 Port cap_valid  input  1  a DUT sample is present this cycle.
REQ-008 Port cap_ready  output  1  block will accept the sample this cycle.
REQ-009 Port cap_a, cap_b, cap_out  input  DATA_WIDTH each  operand A, operand B and DUT result.
REQ-010 Port rd_en  input  1  request to pop the oldest record.
REQ-011 Port rd_data  output  3*DATA_WIDTH  popped record {a,b,out}, a in MSBs (same layout as the team's .tv vector lines).
REQ-012 Port rd_valid  output  1  rd_data is valid this cycle.
REQ-013 Port count  output  clog2(DEPTH+1)  records currently stored.
REQ-014 Port state_o  output  2  current FSM state.
REQ-015 Port dropped  output  16  samples offered while not ready during a session, saturating at 0xFFFF.

Function
REQ-016 FSM states: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-017 IDLE -> ARMED on arm; ARMED -> CAPTURE on first accepted sample; ARMED/CAPTURE -> DONE on stop or when count reaches DEPTH; DONE -> ARMED on arm; IDLE/DONE ignore stop.
REQ-018 arm in ARMED/CAPTURE is ignored; arm in DONE clears dropped but not stored records.
REQ-019 cap_ready = (state is ARMED or CAPTURE) and count < DEPTH, derived from registered state only (no combinational path from cap_valid).
REQ-020 A sample is accepted when cap_valid and cap_ready are both 1; record {cap_a,cap_b,cap_out} written at write pointer, pointer increments modulo DEPTH.
REQ-021 stop and an accepted sample in the same cycle: sample is stored, then FSM enters DONE.
REQ-022 dropped increments when cap_valid=1 and cap_ready=0 while state is ARMED, CAPTURE or DONE-entered-by-full.
REQ-023 Pop occurs when rd_en=1 and count>0; rd_data and rd_valid are registered, valid exactly one cycle after rd_en; rd_en with count=0 is ignored, rd_valid stays 0.
REQ-024 Reads are allowed in every state; read pointer increments modulo DEPTH.
REQ-025 Simultaneous accept and pop: count unchanged, both pointers advance.
REQ-026 When full, a pop in the same cycle does not enable acceptance in that cycle; cap_ready rises the following cycle if state still permits.
REQ-027 rd_data holds its last value when rd_valid=0.
REQ-028 Pointer wrap-around from DEPTH-1 to 0 shall not corrupt count or ordering.

Reset
REQ-029 reset asserted: state=IDLE, pointers=0, count=0, dropped=0, rd_valid=0, rd_data=0, cap_ready=0, immediately without waiting for clock.
REQ-030 reset mid-session discards all stored records; memory contents need not be cleared.

Structure
REQ-031 Shared package holds FSM state encodings and RECORD_WIDTH = 3*DATA_WIDTH default 96.
REQ-032 Storage is one sub-module, capture_mem: simple dual-port synchronous RAM, one write port, one registered read port, no reset on array.

Verification
REQ-033 arm, push 3 samples (1,2,3),(4,5,6),(7,8,9) -> state CAPTURE, count=3; three rd_en -> rd_data 0x..01_..02_..03 etc. in order, rd_valid one cycle after each rd_en.
REQ-034 arm, push 16 samples with cap_valid held, then 2 more -> cap_ready falls after 16th, state DONE, count=16, dropped=2.
REQ-035 Fill to 16, pop 1 while cap_valid=1 same cycle -> no accept that cycle, count=15; next cycle after arm-less DONE, cap_ready stays 0 (DONE).
REQ-036 In CAPTURE with count=5, push and pop each cycle for 20 cycles -> count stays 5, data order preserved across pointer wrap.
REQ-037 stop coincident with accepted sample 0xA/0xB/0xC -> record stored, state DONE next cycle; rd_en on empty -> rd_valid=0.
REQ-038 Assert reset asynchronously mid-capture with count=7 -> count=0, state IDLE, cap_ready=0 before next clock edge.

Source files
------------

// File: rtl/vector_capture_pkg.sv
// Shared definitions for the vector capture block: FSM encodings, record
// geometry and the saturating drop-counter helper.
package vector_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } vc_state_e;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int RECORD_WIDTH   = 3 * DATA_WIDTH_DEF;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == DROP_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/vector_capture_mem.sv
// Record storage: simple dual-port RAM with one write port and a registered
// read port. The array itself is never reset; only the output register is.
module capture_mem
  import vector_capture_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = RECORD_WIDTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output holds its last value between reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vector_capture.sv
// Test-vector capture FIFO: records {a,b,out} samples during an armed session
// and lets them be popped in arrival order at any time.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | after reset, waiting for arm
//   ST_ARMED   | session open, no sample accepted yet
//   ST_CAPTURE | session open, at least one sample accepted
//   ST_DONE    | session closed by stop or by the buffer filling up
module vector_capture
  import vector_capture_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       stop,
  input  logic                       cap_valid,
  output logic                       cap_ready,
  input  logic [DATA_WIDTH-1:0]      cap_a,
  input  logic [DATA_WIDTH-1:0]      cap_b,
  input  logic [DATA_WIDTH-1:0]      cap_out,
  input  logic                       rd_en,
  output logic [3*DATA_WIDTH-1:0]    rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [1:0]                 state_o,
  output logic [15:0]                dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = 3 * DATA_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  vc_state_e       state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     dropped_q, dropped_d;
  logic            full_done_q, full_done_d;
  logic            rd_valid_q;
  logic            session, accept, pop, hit_full;

  // Ready depends only on registered state so cap_valid never loops back.
  assign session   = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign cap_ready = session && (count_q < FULL_CNT);
  assign accept    = cap_valid && cap_ready;
  assign pop       = rd_en && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  assign hit_full = (count_d == FULL_CNT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      full_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_done_q <= full_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    full_done_d = full_done_q;
    case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED, ST_CAPTURE: begin
        if (stop || hit_full) begin
          state_d     = ST_DONE;
          full_done_d = hit_full && !stop;
        end else if (accept) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        if (arm) begin
          state_d     = ST_ARMED;
          full_done_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        full_done_d = 1'b0;
      end
    endcase
  end

  // Drops are counted during a session and after a full-buffer stop, but not
  // after an explicit stop.
  always_comb begin
    dropped_d = dropped_q;
    if ((state_q == ST_DONE) && arm) begin
      dropped_d = '0;
    end else if (cap_valid && !cap_ready &&
                 (session || ((state_q == ST_DONE) && full_done_q))) begin
      dropped_d = sat_inc16(dropped_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dropped_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      dropped_q  <= dropped_d;
      rd_valid_q <= pop;
    end
  end

  capture_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (RW),
    .ADDR_W (AW)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (accept),
    .wr_addr (wr_ptr_q),
    .wr_data ({cap_a, cap_b, cap_out}),
    .rd_en   (pop),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign state_o  = state_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_vector_capture.sv
// Scoreboard bench for vector_capture: accepted samples are queued as they are
// driven and compared against rd_data when the pop result appears.
module tb_vector_capture;
  import vector_capture_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int RW    = 3 * DW;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          arm, stop, cap_valid, rd_en;
  logic          cap_ready, rd_valid;
  logic [DW-1:0] cap_a, cap_b, cap_out;
  logic [RW-1:0] rd_data;
  logic [CW-1:0] count;
  logic [1:0]    state_o;
  logic [15:0]   dropped;

  int n_tests = 0;
  int n_fail  = 0;

  logic [RW-1:0] sb [$];
  vc_state_e     m_state;
  int            m_count;
  logic [15:0]   m_dropped;
  logic          m_full_done;
  logic [RW-1:0] last_rd;

  vector_capture #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .arm       (arm),
    .stop      (stop),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .cap_a     (cap_a),
    .cap_b     (cap_b),
    .cap_out   (cap_out),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .state_o   (state_o),
    .dropped   (dropped)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state     = ST_IDLE;
    m_count     = 0;
    m_dropped   = 16'd0;
    m_full_done = 1'b0;
    last_rd     = '0;
    sb.delete();
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"},   128'(count),   128'(m_count));
    chk({tag, "_state"},   128'(state_o), 128'(m_state));
    chk({tag, "_dropped"}, 128'(dropped), 128'(m_dropped));
  endtask

  // One clock cycle of stimulus; called at posedge+1.
  task automatic drive(input logic i_arm, input logic i_stop, input logic v,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] o, input logic rd);
    logic m_ready, acc, pop;
    int   cnt_n;
    arm = i_arm; stop = i_stop; cap_valid = v;
    cap_a = a; cap_b = b; cap_out = o; rd_en = rd;
    m_ready = ((m_state == ST_ARMED) || (m_state == ST_CAPTURE)) && (m_count < DEPTH);
    chk("cap_ready", 128'(cap_ready), 128'(m_ready));
    acc = v && m_ready;
    pop = rd && (m_count > 0);
    if (acc) sb.push_back({a, b, o});
    cnt_n = m_count + (acc ? 1 : 0) - (pop ? 1 : 0);
    if ((m_state == ST_DONE) && i_arm)
      m_dropped = 16'd0;
    else if (v && !m_ready && (m_state == ST_ARMED || m_state == ST_CAPTURE ||
             (m_state == ST_DONE && m_full_done)) && m_dropped != 16'hFFFF)
      m_dropped = m_dropped + 16'd1;
    case (m_state)
      ST_IDLE: if (i_arm) m_state = ST_ARMED;
      ST_ARMED, ST_CAPTURE: begin
        if (i_stop || cnt_n == DEPTH) begin
          m_full_done = !i_stop && (cnt_n == DEPTH);
          m_state     = ST_DONE;
        end else if (acc) begin
          m_state = ST_CAPTURE;
        end
      end
      ST_DONE: if (i_arm) begin m_state = ST_ARMED; m_full_done = 1'b0; end
      default: m_state = ST_IDLE;
    endcase
    m_count = cnt_n;
    @(posedge clock); #1;
    arm = 1'b0; stop = 1'b0; cap_valid = 1'b0; rd_en = 1'b0;
    chk("rd_valid", 128'(rd_valid), 128'(pop));
    if (pop) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 128'(sb.size()), 128'd1);
      end else begin
        last_rd = sb.pop_front();
        chk("rd_data", 128'(rd_data), 128'(last_rd));
      end
    end else begin
      chk("rd_hold", 128'(rd_data), 128'(last_rd));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic push(input int a, input int b, input int o);
    drive(1'b0, 1'b0, 1'b1, 32'(a), 32'(b), 32'(o), 1'b0);
  endtask

  task automatic pop_one();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic do_arm();
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_stop();
    drive(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; arm = 1'b0; stop = 1'b0; cap_valid = 1'b0; rd_en = 1'b0;
    cap_a = '0; cap_b = '0; cap_out = '0;
    model_reset();
    #12;
    chk("rst_state",    128'(state_o),   128'd0);
    chk("rst_count",    128'(count),     128'd0);
    chk("rst_ready",    128'(cap_ready), 128'd0);
    chk("rst_rd_valid", 128'(rd_valid),  128'd0);
    chk("rst_rd_data",  128'(rd_data),   128'd0);
    chk("rst_dropped",  128'(dropped),   128'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Basic capture and in-order readback.
    do_arm();
    chk("armed_state", 128'(state_o), 128'(ST_ARMED));
    push(1, 2, 3); push(4, 5, 6); push(7, 8, 9);
    chk("cap3_state", 128'(state_o), 128'(ST_CAPTURE));
    chk("cap3_count", 128'(count), 128'd3);
    pop_one();
    chk("first_rec", 128'(rd_data), 128'h00000001_00000002_00000003);
    pop_one(); pop_one();
    chk("third_rec", 128'(rd_data), 128'h00000007_00000008_00000009);
    idle(1);
    check_model("drain3");
    do_stop();
    chk("stop_state", 128'(state_o), 128'(ST_DONE));

    // Fill to full with cap_valid held, two extra samples dropped.
    do_arm();
    for (int i = 0; i < 18; i++) begin
      push(i + 16, i + 100, i * 3);
      if (i == 15) chk("ready_full", 128'(cap_ready), 128'd0);
    end
    chk("full_state",   128'(state_o), 128'(ST_DONE));
    chk("full_count",   128'(count),   128'd16);
    chk("full_dropped", 128'(dropped), 128'd2);

    // Pop while full with a sample offered: no accept, stays DONE.
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD, 32'hBEEF, 32'hCAFE, 1'b1);
    chk("popfull_count", 128'(count), 128'd15);
    idle(1);
    chk("popfull_ready", 128'(cap_ready), 128'd0);
    check_model("popfull");
    for (int i = 0; i < 15; i++) pop_one();
    idle(1);
    check_model("drain16");

    // Steady push+pop across pointer wrap.
    do_arm();
    chk("rearm_dropped", 128'(dropped), 128'd0);
    for (int i = 0; i < 5; i++) push(i + 200, i + 300, i + 400);
    for (int i = 0; i < 20; i++)
      drive(1'b0, 1'b0, 1'b1, 32'(i + 500), 32'(i + 600), 32'(i + 700), 1'b1);
    chk("stream_count", 128'(count), 128'd5);
    for (int i = 0; i < 5; i++) pop_one();
    idle(1);
    check_model("stream_drain");

    // stop coincident with an accepted sample, then read on empty.
    drive(1'b0, 1'b1, 1'b1, 32'hA, 32'hB, 32'hC, 1'b0);
    chk("stopacc_state", 128'(state_o), 128'(ST_DONE));
    chk("stopacc_count", 128'(count), 128'd1);
    pop_one();
    chk("stopacc_rec", 128'(rd_data), 128'h0000000A_0000000B_0000000C);
    pop_one();
    chk("empty_rd_valid", 128'(rd_valid), 128'd0);

    // Asynchronous reset mid-capture.
    do_arm();
    for (int i = 0; i < 7; i++) push(i + 800, i + 900, i + 1000);
    chk("pre_rst_count", 128'(count), 128'd7);
    #3 reset = 1'b1;
    #1;
    chk("arst_count", 128'(count),     128'd0);
    chk("arst_state", 128'(state_o),   128'(ST_IDLE));
    chk("arst_ready", 128'(cap_ready), 128'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();

    // Operation resumes after reset.
    do_arm();
    push(32'h11, 32'h22, 32'h33);
    pop_one();
    chk("post_rst_rec", 128'(rd_data), 128'h00000011_00000022_00000033);
    idle(2);
    check_model("final");
    chk("sb_drained", 128'(sb.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
